// File: rtl/prio_arbiter_pkg.sv
// prio_arbiter_pkg: shared types for the priority arbiter.
//   arb_mode_e selects between fixed lowest-index-first and round-robin selection.
package prio_arbiter_pkg;

    typedef enum logic {
        ArbFixed      = 1'b0,
        ArbRoundRobin = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational "first set bit at or after start, with wrap" search.
//   req   - request vector, bit i is requester i
//   start - index at which the search begins (0 gives plain lowest-index-first)
//   found - at least one bit of req is set
//   idx   - winning index; 0 when nothing is found
// Two passes run in parallel: one over the requests at or above start, one over
// all requests. The masked result wins when it exists, otherwise the search wraps.
module prio_find #(
    parameter int unsigned NumReq   = 16,
    parameter int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] start,
    output logic                found,
    output logic [IdxWidth-1:0] idx
);

    logic [NumReq-1:0]   mask;
    logic [NumReq-1:0]   masked;
    logic                masked_found;
    logic                any_found;
    logic [IdxWidth-1:0] masked_idx;
    logic [IdxWidth-1:0] any_idx;

    // Thermometer mask: bit i is kept when i >= start.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            mask[i] = (i >= 32'(start));
        end
    end

    assign masked = req & mask;

    // Scan from the top down so the last hit written is the lowest set index.
    always_comb begin
        masked_found = 1'b0;
        masked_idx   = '0;
        any_found    = 1'b0;
        any_idx      = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                masked_found = 1'b1;
                masked_idx   = IdxWidth'(i);
            end
            if (req[i]) begin
                any_found = 1'b1;
                any_idx   = IdxWidth'(i);
            end
        end
    end

    // A masked hit implies an unmasked one, so any_found alone decides validity.
    assign found = any_found;
    assign idx   = masked_found ? masked_idx : any_idx;

endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: priority / round-robin arbiter with a registered, handshaked grant.
//   clk_i        - clock
//   rst_ni       - asynchronous active-low reset
//   mode_i       - ArbFixed (lowest index wins) or ArbRoundRobin (search from ptr)
//   req_i        - request vector
//   lock_i       - holds the round-robin pointer on an accepted grant
//   gnt_valid_o  - grant register holds a valid grant
//   gnt_ready_i  - consumer accepts the grant
//   gnt_idx_o    - granted index
//   gnt_onehot_o - one-hot form of gnt_idx_o, zero when not valid
//   ptr_o        - round-robin start pointer
// Every output comes straight from a flop; req_i is only looked at on load cycles.
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 16,
    parameter int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  arb_mode_e           mode_i,
    input  logic [NumReq-1:0]   req_i,
    input  logic                lock_i,
    output logic                gnt_valid_o,
    input  logic                gnt_ready_i,
    output logic [IdxWidth-1:0] gnt_idx_o,
    output logic [NumReq-1:0]   gnt_onehot_o,
    output logic [IdxWidth-1:0] ptr_o
);

    logic                load;
    logic                accept;
    logic                rr_mode;
    logic [IdxWidth-1:0] search_start;
    logic                cand_found;
    logic [IdxWidth-1:0] cand_idx;

    logic                gnt_valid_q, gnt_valid_d;
    logic [IdxWidth-1:0] gnt_idx_q,   gnt_idx_d;
    logic [NumReq-1:0]   gnt_onehot_q, gnt_onehot_d;
    logic [IdxWidth-1:0] ptr_q,       ptr_d;

    // The register refills whenever it is empty or its content is being taken.
    assign load    = !gnt_valid_q || gnt_ready_i;
    assign accept  = gnt_valid_q && gnt_ready_i;
    assign rr_mode = (mode_i == ArbRoundRobin);

    // Selection always uses the pre-update pointer, so back-to-back grants see
    // the pointer one grant late; this keeps the pointer off the search path.
    assign search_start = rr_mode ? ptr_q : '0;

    prio_find #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_find (
        .req   (req_i),
        .start (search_start),
        .found (cand_found),
        .idx   (cand_idx)
    );

    // Grant register next state: hold while stalled, otherwise capture the candidate.
    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        if (load) begin
            gnt_valid_d = cand_found;
            gnt_idx_d   = cand_found ? cand_idx : '0;
            for (int unsigned i = 0; i < NumReq; i++) begin
                gnt_onehot_d[i] = cand_found && (cand_idx == IdxWidth'(i));
            end
        end
    end

    // Pointer moves past the accepted index; wrap at NumReq-1 so non-power-of-two
    // sizes never point at a nonexistent requester.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && rr_mode && !lock_i) begin
            if (gnt_idx_q == IdxWidth'(NumReq - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_q + IdxWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            ptr_q        <= '0;
        end else begin
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            ptr_q        <= ptr_d;
        end
    end

    assign gnt_valid_o  = gnt_valid_q;
    assign gnt_idx_o    = gnt_idx_q;
    assign gnt_onehot_o = gnt_onehot_q;
    assign ptr_o        = ptr_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: self-checking bench for prio_arbiter, NumReq=16 and NumReq=5.
module tb_prio_arbiter;
    import prio_arbiter_pkg::*;

    typedef struct packed {
        logic        v;
        logic [3:0]  idx;
        logic [15:0] oh;
        logic [3:0]  ptr;
    } exp_t;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    arb_mode_e mode  = ArbFixed;
    logic      lock  = 1'b0;
    logic      ready = 1'b1;
    logic [15:0] req16 = '0;
    logic [4:0]  req5  = '0;

    logic        gnt_valid16, gnt_valid5;
    logic [3:0]  gnt_idx16, ptr16;
    logic [15:0] gnt_onehot16;
    logic [2:0]  gnt_idx5, ptr5;
    logic [4:0]  gnt_onehot5;

    exp_t obs16, obs5;
    assign obs16 = {gnt_valid16, gnt_idx16, gnt_onehot16, ptr16};
    assign obs5  = {gnt_valid5, 1'b0, gnt_idx5, 11'd0, gnt_onehot5, 1'b0, ptr5};

    exp_t q16[$];
    exp_t q5[$];
    int checks = 0;
    int errors = 0;

    logic m16_v = 1'b0;
    int   m16_idx = 0, m16_ptr = 0;
    logic m5_v = 1'b0;
    int   m5_idx = 0, m5_ptr = 0;

    always #5 clk = ~clk;

    prio_arbiter #(.NumReq(16)) u_dut16 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mode_i       (mode),
        .req_i        (req16),
        .lock_i       (lock),
        .gnt_valid_o  (gnt_valid16),
        .gnt_ready_i  (ready),
        .gnt_idx_o    (gnt_idx16),
        .gnt_onehot_o (gnt_onehot16),
        .ptr_o        (ptr16)
    );

    prio_arbiter #(.NumReq(5)) u_dut5 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mode_i       (mode),
        .req_i        (req5),
        .lock_i       (lock),
        .gnt_valid_o  (gnt_valid5),
        .gnt_ready_i  (ready),
        .gnt_idx_o    (gnt_idx5),
        .gnt_onehot_o (gnt_onehot5),
        .ptr_o        (ptr5)
    );

    // Walk start, start+1, ... modulo n; first set bit wins, -1 when none.
    function automatic int find(input logic [15:0] rq, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (rq[j]) return j;
        end
        return -1;
    endfunction

    function automatic exp_t mk(input logic v, input int idx, input int ptr);
        exp_t e;
        e.v   = v;
        e.idx = idx[3:0];
        e.oh  = v ? (16'd1 << idx) : 16'd0;
        e.ptr = ptr[3:0];
        return e;
    endfunction

    // One clock of the reference model, using the inputs the DUT sees at the edge.
    task automatic model_step(input int n, input logic [15:0] rq,
                              inout logic v, inout int idx, inout int ptr);
        int  nptr, c;
        bit  ld, acc;
        ld   = !v || ready;
        acc  = v && ready;
        nptr = ptr;
        if (acc && mode == ArbRoundRobin && !lock) nptr = (idx == n - 1) ? 0 : idx + 1;
        if (ld) begin
            c   = find(rq, (mode == ArbRoundRobin) ? ptr : 0, n);
            v   = (c >= 0);
            idx = (c >= 0) ? c : 0;
        end
        ptr = nptr;
    endtask

    // Push expectations for both instances, then advance one clock and settle.
    task automatic tick();
        model_step(16, req16, m16_v, m16_idx, m16_ptr);
        q16.push_back(mk(m16_v, m16_idx, m16_ptr));
        model_step(5, {11'd0, req5}, m5_v, m5_idx, m5_ptr);
        q5.push_back(mk(m5_v, m5_idx, m5_ptr));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        m16_v = 1'b0; m16_idx = 0; m16_ptr = 0;
        m5_v  = 1'b0; m5_idx  = 0; m5_ptr  = 0;
        q16.delete();
        q5.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        #3;
        checks++;
        if (obs16 !== '0 || obs5 !== '0) begin
            errors++;
            $display("FAIL reset_state: got16 %h got5 %h want 0", obs16, obs5);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode  = ArbFixed;
        ready = 1'b0;
        req16 = 16'h0008;
        tick();
        e = q16.pop_front();
        checks++;
        if (obs16 !== e || !gnt_valid16 || gnt_idx16 !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset_grant: got %h want %h (v,idx,oh,ptr)", obs16, e);
        end
        // Reset lands mid-cycle while the grant is stalled.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs16 !== '0 || obs5 !== '0) begin
            errors++;
            $display("FAIL reset_mid_grant: got16 %h got5 %h want 0", obs16, obs5);
        end
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req16 = 16'h0010;
        ready = 1'b1;
        tick();
        e = q16.pop_front();
        checks++;
        if (obs16 !== e || gnt_idx16 !== 4'd4 || !gnt_valid16) begin
            errors++;
            $display("FAIL post_reset_grant: got %h want %h (v,idx,oh,ptr)", obs16, e);
        end
    endtask

    task automatic test_fixed();
        exp_t e;
        q16.delete();
        mode  = ArbFixed;
        ready = 1'b1;
        req16 = 16'hA050;
        for (int c = 0; c < 6; c++) begin
            tick();
            e = q16.pop_front();
            checks++;
            if (obs16 !== e || gnt_idx16 !== 4'd4 || gnt_onehot16 !== 16'h0010 ||
                ptr16 !== 4'd0) begin
                errors++;
                $display("FAIL fixed cycle %0d: got %h want %h (v,idx,oh,ptr)", c, obs16, e);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int exp_idx[9] = '{0, 0, 5, 5, 10, 10, 15, 15, 0};
        int exp_ptr[9] = '{0, 1, 1, 6, 6, 11, 11, 0, 0};
        apply_reset();
        mode  = ArbRoundRobin;
        lock  = 1'b0;
        ready = 1'b1;
        req16 = 16'h8421;
        for (int c = 0; c < 9; c++) begin
            tick();
            e = q16.pop_front();
            checks++;
            if (obs16 !== e || int'(gnt_idx16) != exp_idx[c] || int'(ptr16) != exp_ptr[c]) begin
                errors++;
                $display("FAIL round_robin cycle %0d: got %h want %h idx %0d ptr %0d",
                         c, obs16, e, exp_idx[c], exp_ptr[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        q16.delete();
        mode  = ArbFixed;
        ready = 1'b1;
        req16 = 16'h0008;
        tick();
        e = q16.pop_front();
        checks++;
        if (obs16 !== e || gnt_idx16 !== 4'd3) begin
            errors++;
            $display("FAIL bp_setup: got %h want %h (v,idx,oh,ptr)", obs16, e);
        end
        ready = 1'b0;
        req16 = 16'h0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            e = q16.pop_front();
            checks++;
            if (obs16 !== e || gnt_idx16 !== 4'd3 || !gnt_valid16 ||
                gnt_onehot16 !== 16'h0008) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got %h want %h (v,idx,oh,ptr)", c, obs16, e);
            end
        end
        ready = 1'b1;
        tick();
        e = q16.pop_front();
        checks++;
        if (obs16 !== e || gnt_idx16 !== 4'd8 || !gnt_valid16) begin
            errors++;
            $display("FAIL bp_release: got %h want %h (v,idx,oh,ptr)", obs16, e);
        end
    endtask

    task automatic test_wrap5();
        exp_t e;
        int exp_idx[8] = '{0, 0, 4, 4, 0, 0, 4, 4};
        int exp_ptr[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
        apply_reset();
        mode  = ArbRoundRobin;
        lock  = 1'b0;
        ready = 1'b1;
        req5  = 5'b10001;
        for (int c = 0; c < 8; c++) begin
            tick();
            e = q5.pop_front();
            checks++;
            if (obs5 !== e || int'(gnt_idx5) != exp_idx[c] || int'(ptr5) != exp_ptr[c] ||
                ptr5 > 3'd4) begin
                errors++;
                $display("FAIL wrap5 cycle %0d: got %h want %h idx %0d ptr %0d",
                         c, obs5, e, exp_idx[c], exp_ptr[c]);
            end
        end
        req5 = '0;
    endtask

    task automatic test_lock_empty();
        exp_t e;
        apply_reset();
        mode  = ArbRoundRobin;
        lock  = 1'b1;
        ready = 1'b1;
        req16 = 16'h0006;
        for (int c = 0; c < 5; c++) begin
            tick();
            e = q16.pop_front();
            checks++;
            if (obs16 !== e || gnt_idx16 !== 4'd1 || ptr16 !== 4'd0 || !gnt_valid16) begin
                errors++;
                $display("FAIL lock cycle %0d: got %h want %h (v,idx,oh,ptr)", c, obs16, e);
            end
        end
        req16 = '0;
        tick();
        e = q16.pop_front();
        checks++;
        if (obs16 !== e || gnt_valid16 !== 1'b0 || gnt_onehot16 !== 16'h0000) begin
            errors++;
            $display("FAIL empty: got %h want %h (v,idx,oh,ptr)", obs16, e);
        end
        lock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_wrap5();
        test_lock_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
